// File: rtl/instruction_fetch.sv
// Instruction fetch stage of the pipelined MIPS core.
//
// Holds the byte-addressed program counter, a word-addressed instruction memory
// (program-loaded by the debug unit while idle) and the run/step/halt control FSM.
// Outputs feed the IF/ID pipeline register, which captures them on the next edge.
//
// Optional feature macro: IF_STEP_MODE_EN enables single-step execution via i_step.
// With it undefined, i_step is ignored and IDLE leaves only on i_run.
//
// Ports:
//   i_clock, i_reset       rising-edge clock, asynchronous active-high reset
//   i_mem_wr_en/addr/data  program-load write port (accepted only in IDLE)
//   i_run, i_step          start continuous execution / single-step pulse
//   i_stall                hold PC this cycle (hazard unit)
//   i_branch, i_branch_target  redirect PC to a byte address
//   o_instruccion          word at mem[pc[ADDR_WIDTH+1:2]]
//   o_pc                   pc + 4
//   o_valid                fetch advances this cycle
//   o_halted               HALT word has been fetched
//   o_state                current FSM state
module instruction_fetch #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_mem_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_mem_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_wr_data,
  input  logic                  i_run,
  input  logic                  i_step,
  input  logic                  i_stall,
  input  logic                  i_branch,
  input  logic [DATA_WIDTH-1:0] i_branch_target,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_valid,
  output logic                  o_halted,
  output logic [1:0]            o_state
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] HaltWord = {DATA_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StStepWait = 2'd2,
    StHalt     = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] mem_d [Depth];

  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  step_adv;
  logic                  advance;
  logic                  unused_inputs;

  // Branch targets are forced word-aligned, so the low two bits never matter.
`ifdef IF_STEP_MODE_EN
  assign unused_inputs = ^i_branch_target[1:0];
`else
  assign unused_inputs = ^{i_step, i_branch_target[1:0]};
`endif

  assign rd_idx        = pc_q[ADDR_WIDTH+1:2];
  assign o_instruccion = mem_q[rd_idx];
  assign o_pc          = pc_q + DATA_WIDTH'(4);
  assign o_valid       = advance;
  assign o_halted      = (state_q == StHalt);
  assign o_state       = state_q;

  always_comb begin
    step_adv = 1'b0;
`ifdef IF_STEP_MODE_EN
    // i_run wins over i_step: no step advance on a cycle that starts running.
    step_adv = ((state_q == StIdle) || (state_q == StStepWait)) && i_step && !i_run;
`endif
    // A branch overrides a stall while running.
    advance = ((state_q == StRun) && (!i_stall || i_branch)) || step_adv;

    state_d = state_q;
    pc_d    = pc_q;

    case (state_q)
      StIdle: begin
        if (i_run) begin
          state_d = StRun;
        end else if (step_adv) begin
          state_d = StStepWait;
        end
      end
      StStepWait: begin
        if (i_run) begin
          state_d = StRun;
        end
      end
      default: ;
    endcase

    if (advance) begin
      if (i_branch) begin
        pc_d = {i_branch_target[DATA_WIDTH-1:2], 2'b00};
      end else if (o_instruccion == HaltWord) begin
        state_d = StHalt;
      end else begin
        pc_d = pc_q + DATA_WIDTH'(4);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (i_mem_wr_en && (state_q == StIdle)) begin
      mem_d[i_mem_wr_addr] = i_mem_wr_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch. Inputs change just after the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_instruction_fetch;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_mem_wr_en;
  logic [7:0]  i_mem_wr_addr;
  logic [31:0] i_mem_wr_data;
  logic        i_run;
  logic        i_step;
  logic        i_stall;
  logic        i_branch;
  logic [31:0] i_branch_target;
  logic [31:0] o_instruccion;
  logic [31:0] o_pc;
  logic        o_valid;
  logic        o_halted;
  logic [1:0]  o_state;

  int checks = 0;
  int errors = 0;

  always #5 i_clock = ~i_clock;

  instruction_fetch #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_mem_wr_en    (i_mem_wr_en),
    .i_mem_wr_addr  (i_mem_wr_addr),
    .i_mem_wr_data  (i_mem_wr_data),
    .i_run          (i_run),
    .i_step         (i_step),
    .i_stall        (i_stall),
    .i_branch       (i_branch),
    .i_branch_target(i_branch_target),
    .o_instruccion  (o_instruccion),
    .o_pc           (o_pc),
    .o_valid        (o_valid),
    .o_halted       (o_halted),
    .o_state        (o_state)
  );

  task automatic clear_inputs();
    i_mem_wr_en     = 1'b0;
    i_mem_wr_addr   = '0;
    i_mem_wr_data   = '0;
    i_run           = 1'b0;
    i_step          = 1'b0;
    i_stall         = 1'b0;
    i_branch        = 1'b0;
    i_branch_target = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset = 1'b1;
    @(negedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
    @(negedge i_clock);
    i_mem_wr_en   = 1'b1;
    i_mem_wr_addr = addr;
    i_mem_wr_data = data;
    @(negedge i_clock);
    i_mem_wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_reset = 1'b1;
    #2;
    checks++; if (o_pc !== 32'd4) begin errors++; $display("FAIL reset_pc: got %h expected %h", o_pc, 32'd4); end
    checks++; if (o_instruccion !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", o_instruccion); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", o_halted); end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_state); end
    @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  task automatic test_load_run();
    do_reset();
    load_word(8'd0, 32'h20010005);
    load_word(8'd1, 32'h20020003);
    load_word(8'd2, 32'hFFFFFFFF);
    i_run = 1'b1;
    #1;
    checks++; if (o_instruccion !== 32'h20010005) begin errors++; $display("FAIL load_word0: got %h expected 20010005", o_instruccion); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL idle_run_valid: got %b expected 0", o_valid); end
    @(negedge i_clock); i_run = 1'b0; #1;
    checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL run_state: got %0d expected 1", o_state); end
    checks++; if (o_pc !== 32'd4 || o_valid !== 1'b1) begin errors++; $display("FAIL run_c0: pc %h valid %b expected 4 1", o_pc, o_valid); end
    @(negedge i_clock); #1;
    checks++; if (o_pc !== 32'd8 || o_valid !== 1'b1 || o_instruccion !== 32'h20020003) begin errors++; $display("FAIL run_c1: pc %h valid %b instr %h expected 8 1 20020003", o_pc, o_valid, o_instruccion); end
    @(negedge i_clock); #1;
    checks++; if (o_pc !== 32'd12 || o_valid !== 1'b1 || o_instruccion !== 32'hFFFFFFFF) begin errors++; $display("FAIL run_c2: pc %h valid %b instr %h expected c 1 ffffffff", o_pc, o_valid, o_instruccion); end
    checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b expected 0", o_halted); end
    @(negedge i_clock); #1;
    checks++; if (o_halted !== 1'b1 || o_valid !== 1'b0 || o_state !== 2'd3) begin errors++; $display("FAIL halted: halted %b valid %b state %0d expected 1 0 3", o_halted, o_valid, o_state); end
    checks++; if (o_pc !== 32'd12) begin errors++; $display("FAIL halt_pc: got %h expected c", o_pc); end
    @(negedge i_clock); i_run = 1'b1; #1;
    checks++; if (o_pc !== 32'd12 || o_valid !== 1'b0 || o_state !== 2'd3) begin errors++; $display("FAIL halt_sticky: pc %h valid %b state %0d expected c 0 3", o_pc, o_valid, o_state); end
    i_run = 1'b0;
  endtask

  task automatic test_write_with_run();
    do_reset();
    @(negedge i_clock);
    i_mem_wr_en = 1'b1; i_mem_wr_addr = 8'd0; i_mem_wr_data = 32'hFFFFFFFF; i_run = 1'b1;
    #1;
    checks++; if (o_instruccion !== 32'd0) begin errors++; $display("FAIL wrrun_before: got %h expected 0", o_instruccion); end
    @(negedge i_clock); clear_inputs(); #1;
    checks++; if (o_state !== 2'd1 || o_instruccion !== 32'hFFFFFFFF || o_valid !== 1'b1) begin errors++; $display("FAIL wrrun_after: state %0d instr %h valid %b expected 1 ffffffff 1", o_state, o_instruccion, o_valid); end
    @(negedge i_clock); #1;
    checks++; if (o_halted !== 1'b1 || o_pc !== 32'd4) begin errors++; $display("FAIL wrrun_halt: halted %b pc %h expected 1 4", o_halted, o_pc); end
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge i_clock); i_run = 1'b1;
    @(negedge i_clock); i_run = 1'b0;
    @(negedge i_clock);
    @(negedge i_clock); i_stall = 1'b1; #1;
    checks++; if (o_pc !== 32'd12 || o_valid !== 1'b0) begin errors++; $display("FAIL stall_c0: pc %h valid %b expected c 0", o_pc, o_valid); end
    @(negedge i_clock); #1;
    checks++; if (o_pc !== 32'd12 || o_valid !== 1'b0) begin errors++; $display("FAIL stall_c1: pc %h valid %b expected c 0", o_pc, o_valid); end
    @(negedge i_clock); i_stall = 1'b0; #1;
    checks++; if (o_pc !== 32'd12 || o_valid !== 1'b1) begin errors++; $display("FAIL stall_release: pc %h valid %b expected c 1", o_pc, o_valid); end
    @(negedge i_clock); #1;
    checks++; if (o_pc !== 32'd16) begin errors++; $display("FAIL stall_advance: got %h expected 10", o_pc); end
  endtask

  // Continues from test_stall: running at pc=16 with an all-zero memory.
  task automatic test_branch();
    @(negedge i_clock); i_branch = 1'b1; i_branch_target = 32'h00000042; i_stall = 1'b1; #1;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL branch_stall_valid: got %b expected 1", o_valid); end
    @(negedge i_clock); i_branch = 1'b0; i_stall = 1'b0; #1;
    checks++; if (o_pc !== 32'h44) begin errors++; $display("FAIL branch_stall_pc: got %h expected 44", o_pc); end
    @(negedge i_clock); i_branch = 1'b1; i_branch_target = 32'h00000013;
    @(negedge i_clock); i_branch = 1'b0; #1;
    checks++; if (o_pc !== 32'h14) begin errors++; $display("FAIL branch_align: got %h expected 14", o_pc); end
  endtask

  // Continues in RUN: a write outside IDLE must not reach memory.
  task automatic test_write_in_run();
    @(negedge i_clock);
    i_mem_wr_en = 1'b1; i_mem_wr_addr = 8'd0; i_mem_wr_data = 32'hDEADBEEF;
    @(negedge i_clock); i_mem_wr_en = 1'b0; i_branch = 1'b1; i_branch_target = 32'd0;
    @(negedge i_clock); i_branch = 1'b0; #1;
    checks++; if (o_pc !== 32'd4 || o_instruccion !== 32'd0) begin errors++; $display("FAIL run_write_ignored: pc %h instr %h expected 4 0", o_pc, o_instruccion); end
  endtask

  task automatic test_branch_idle();
    do_reset();
    @(negedge i_clock); i_branch = 1'b1; i_branch_target = 32'h80; #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL idle_branch_valid: got %b expected 0", o_valid); end
    @(negedge i_clock); i_branch = 1'b0; #1;
    checks++; if (o_pc !== 32'd4) begin errors++; $display("FAIL idle_branch_pc: got %h expected 4", o_pc); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load_word(8'd0, 32'hABCD0001);
    load_word(8'd8, 32'h12345678);
    i_run = 1'b1;
    @(negedge i_clock); i_run = 1'b0; i_branch = 1'b1; i_branch_target = 32'h20;
    @(negedge i_clock); i_branch = 1'b0; #1;
    checks++; if (o_pc !== 32'h24 || o_instruccion !== 32'h12345678) begin errors++; $display("FAIL pre_reset: pc %h instr %h expected 24 12345678", o_pc, o_instruccion); end
    #1; i_reset = 1'b1; #1;
    checks++; if (o_pc !== 32'd4 || o_instruccion !== 32'd0) begin errors++; $display("FAIL midreset_pc_instr: pc %h instr %h expected 4 0", o_pc, o_instruccion); end
    checks++; if (o_valid !== 1'b0 || o_halted !== 1'b0 || o_state !== 2'd0) begin errors++; $display("FAIL midreset_ctrl: valid %b halted %b state %0d expected 0 0 0", o_valid, o_halted, o_state); end
    @(negedge i_clock); i_reset = 1'b0;
  endtask

  task automatic test_step();
    do_reset();
`ifdef IF_STEP_MODE_EN
    @(negedge i_clock); i_step = 1'b1; #1;
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'd4) begin errors++; $display("FAIL step1: valid %b pc %h expected 1 4", o_valid, o_pc); end
    @(negedge i_clock); i_step = 1'b0; #1;
    checks++; if (o_valid !== 1'b0 || o_state !== 2'd2 || o_pc !== 32'd8) begin errors++; $display("FAIL step1_gap: valid %b state %0d pc %h expected 0 2 8", o_valid, o_state, o_pc); end
    @(negedge i_clock); i_step = 1'b1; #1;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL step2: got %b expected 1", o_valid); end
    @(negedge i_clock); i_step = 1'b0; #1;
    checks++; if (o_valid !== 1'b0 || o_pc !== 32'd12) begin errors++; $display("FAIL step2_gap: valid %b pc %h expected 0 c", o_valid, o_pc); end
    @(negedge i_clock); i_step = 1'b1;
    @(negedge i_clock); i_step = 1'b0; #1;
    checks++; if (o_pc !== 32'd16 || o_state !== 2'd2) begin errors++; $display("FAIL step3: pc %h state %0d expected 10 2", o_pc, o_state); end
    @(negedge i_clock); i_run = 1'b1; i_step = 1'b1; #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL run_beats_step: got %b expected 0", o_valid); end
    @(negedge i_clock); i_run = 1'b0; i_step = 1'b0; #1;
    checks++; if (o_state !== 2'd1 || o_pc !== 32'd16) begin errors++; $display("FAIL step_to_run: state %0d pc %h expected 1 10", o_state, o_pc); end
`else
    @(negedge i_clock); i_step = 1'b1; #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL step_ignored_valid: got %b expected 0", o_valid); end
    @(negedge i_clock); i_step = 1'b0; #1;
    checks++; if (o_state !== 2'd0 || o_pc !== 32'd4) begin errors++; $display("FAIL step_ignored_state: state %0d pc %h expected 0 4", o_state, o_pc); end
`endif
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_write_with_run();
    test_stall();
    test_branch();
    test_write_in_run();
    test_branch_idle();
    test_reset_mid_run();
    test_step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
